// File: rtl/fractal_pkg.sv
// Shared types and constants for the escape-time fractal engine.
package fractal_pkg;

    localparam int FX_W      = 32;
    localparam int FX_FRAC   = 28;
    // Escape radius squared (4.0), as an integer to be scaled by the fraction width
    localparam int ESCAPE_R2 = 4;

    typedef logic signed [FX_W-1:0] fx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

endpackage

// File: rtl/fractal_iter_step.sv
// One combinational z = z^2 + c step plus the |z|^2 > 4.0 escape test on the current z.
module fractal_iter_step
    import fractal_pkg::*;
#(
    parameter int FW   = 32,
    parameter int FRAC = 28
) (
    input  logic signed [FW-1:0] zr,
    input  logic signed [FW-1:0] zi,
    input  logic signed [FW-1:0] cr,
    input  logic signed [FW-1:0] ci,
    output logic signed [FW-1:0] zr_next,
    output logic signed [FW-1:0] zi_next,
    output logic                 escaped
);

    localparam int PW = 2 * FW;
    localparam logic [FW+1:0] ESC_LIMIT = (FW+2)'(ESCAPE_R2) << FRAC;

    logic signed [PW-1:0] rr_s;
    logic signed [PW-1:0] ii_s;
    logic signed [PW-1:0] ri_s;
    logic        [FW:0]   rr_sat_s;
    logic        [FW:0]   ii_sat_s;
    logic        [FW+1:0] mag_s;

    // Squares are saturated before summing so a huge |z| can never wrap back below 4.0
    always_comb begin
        rr_s     = (PW'(zr) * PW'(zr)) >>> FRAC;
        ii_s     = (PW'(zi) * PW'(zi)) >>> FRAC;
        ri_s     = (PW'(zr) * PW'(zi)) >>> FRAC;
        rr_sat_s = (|rr_s[PW-1:FW+1]) ? {(FW+1){1'b1}} : rr_s[FW:0];
        ii_sat_s = (|ii_s[PW-1:FW+1]) ? {(FW+1){1'b1}} : ii_s[FW:0];
        mag_s    = {1'b0, rr_sat_s} + {1'b0, ii_sat_s};
        escaped  = (mag_s > ESC_LIMIT);
        zr_next  = rr_s[FW-1:0] - ii_s[FW-1:0] + cr;
        zi_next  = {ri_s[FW-2:0], 1'b0} + ci;
    end

endmodule

// File: rtl/fractal_engine.sv
// Escape-time Julia renderer streaming one pixel beat per valid/ready handshake.
// Define FRACTAL_ENGINE_MANDELBROT_EN to honour mode_in (Mandelbrot seeding).
module fractal_engine
    import fractal_pkg::*;
#(
    parameter int FW       = 32,
    parameter int FRAC     = 28,
    parameter int DW       = 8,
    parameter int MAX_ITER = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode_in,
    input  logic [15:0]          width_in,
    input  logic [15:0]          height_in,
    input  logic signed [FW-1:0] cr_in,
    input  logic signed [FW-1:0] ci_in,
    input  logic signed [FW-1:0] dx_in,
    input  logic signed [FW-1:0] dy_in,
    input  logic signed [FW-1:0] x0_in,
    input  logic signed [FW-1:0] y0_in,
    input  logic                 data_ready,
    output logic [DW-1:0]        data,
    output logic                 data_enable,
    output logic                 frame_start,
    output logic                 line_end
);

    localparam logic [15:0] PIX_MAX = 16'((1 << DW) - 1);

    state_t               state_r, state_nx_s;
    logic [15:0]          w_r, h_r, col_r, row_r, iter_r;
    logic signed [FW-1:0] cr_r, ci_r, dx_r, dy_r, x0_r;
    logic signed [FW-1:0] px_r, py_r, zr_r, zi_r, car_r, cai_r;
    logic signed [FW-1:0] zr_nx_s, zi_nx_s;
    logic                 escaped_s, exit_s, xfer_s, last_col_s, last_row_s;
    logic [DW-1:0]        data_r;
    logic                 data_enable_r, frame_start_r, line_end_r;

`ifdef FRACTAL_ENGINE_MANDELBROT_EN
    logic mode_r;
`else
    logic unused_mode_s;
    assign unused_mode_s = mode_in;
`endif

    fractal_iter_step #(.FW(FW), .FRAC(FRAC)) u_step (
        .zr      (zr_r),
        .zi      (zi_r),
        .cr      (car_r),
        .ci      (cai_r),
        .zr_next (zr_nx_s),
        .zi_next (zi_nx_s),
        .escaped (escaped_s)
    );

    assign exit_s     = escaped_s || (iter_r == 16'(MAX_ITER));
    assign xfer_s     = data_enable_r && data_ready;
    assign last_col_s = (col_r == w_r - 16'd1);
    assign last_row_s = (row_r == h_r - 16'd1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((width_in != 16'd0) && (height_in != 16'd0)) state_nx_s = ST_LOAD;
                else                                              state_nx_s = ST_IDLE;
            end
            ST_LOAD: state_nx_s = ST_ITER;
            ST_ITER: begin
                if (exit_s) state_nx_s = ST_EMIT;
                else        state_nx_s = ST_ITER;
            end
            ST_EMIT: begin
                if (!xfer_s)                      state_nx_s = ST_EMIT;
                else if (last_col_s && last_row_s) state_nx_s = ST_IDLE;
                else                              state_nx_s = ST_LOAD;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Shadow configuration, pixel walk, iteration state and registered beat outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_r <= 16'd0;  h_r <= 16'd0;  col_r <= 16'd0;  row_r <= 16'd0;  iter_r <= 16'd0;
            cr_r <= '0;  ci_r <= '0;  dx_r <= '0;  dy_r <= '0;  x0_r <= '0;
            px_r <= '0;  py_r <= '0;  zr_r <= '0;  zi_r <= '0;  car_r <= '0;  cai_r <= '0;
            data_r <= '0;  data_enable_r <= 1'b0;  frame_start_r <= 1'b0;  line_end_r <= 1'b0;
`ifdef FRACTAL_ENGINE_MANDELBROT_EN
            mode_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    w_r <= width_in;  h_r <= height_in;
                    cr_r <= cr_in;  ci_r <= ci_in;  dx_r <= dx_in;  dy_r <= dy_in;  x0_r <= x0_in;
                    px_r <= x0_in;  py_r <= y0_in;  col_r <= 16'd0;  row_r <= 16'd0;
`ifdef FRACTAL_ENGINE_MANDELBROT_EN
                    mode_r <= mode_in;
`endif
                end
                ST_LOAD: begin
                    iter_r <= 16'd0;
`ifdef FRACTAL_ENGINE_MANDELBROT_EN
                    if (mode_r) begin
                        zr_r <= '0;  zi_r <= '0;  car_r <= px_r;  cai_r <= py_r;
                    end else begin
                        zr_r <= px_r;  zi_r <= py_r;  car_r <= cr_r;  cai_r <= ci_r;
                    end
`else
                    zr_r <= px_r;  zi_r <= py_r;  car_r <= cr_r;  cai_r <= ci_r;
`endif
                end
                ST_ITER: begin
                    if (exit_s) begin
                        data_r        <= (iter_r > PIX_MAX) ? {DW{1'b1}} : iter_r[DW-1:0];
                        data_enable_r <= 1'b1;
                        frame_start_r <= (col_r == 16'd0) && (row_r == 16'd0);
                        line_end_r    <= last_col_s;
                    end else begin
                        zr_r   <= zr_nx_s;
                        zi_r   <= zi_nx_s;
                        iter_r <= iter_r + 16'd1;
                    end
                end
                ST_EMIT: begin
                    if (xfer_s) begin
                        data_r <= '0;  data_enable_r <= 1'b0;
                        frame_start_r <= 1'b0;  line_end_r <= 1'b0;
                        // Pixel coordinates advance by subtraction, wrapping modulo 2^FW
                        if (last_col_s) begin
                            col_r <= 16'd0;  px_r <= x0_r;
                            row_r <= row_r + 16'd1;  py_r <= py_r - dy_r;
                        end else begin
                            col_r <= col_r + 16'd1;  px_r <= px_r - dx_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data        = data_r;
    assign data_enable = data_enable_r;
    assign frame_start = frame_start_r;
    assign line_end    = line_end_r;

endmodule

// File: tb/tb_fractal_engine.sv
// Randomized self-checking bench for fractal_engine against a behavioural escape-time model.
module tb_fractal_engine;
    import fractal_pkg::*;

    localparam int MAX_ITER = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode_in = 1'b0;
    logic [15:0] width_in = 16'd0, height_in = 16'd0;
    fx_t         cr_in = '0, ci_in = '0, dx_in = '0, dy_in = '0, x0_in = '0, y0_in = '0;
    logic        data_ready = 1'b1;
    logic [7:0]  data;
    logic        data_enable, frame_start, line_end;

    int vectors = 0, miscompares = 0;
    int ready_mode = 0;

    // model state
    bit model_idle = 1'b1, beat_seen = 1'b0, m_mode = 1'b0;
    int m_w, m_h, m_col, m_row, m_cr, m_ci, m_dx, m_dy, m_x0, m_y0;
    int exp_cnt, wait_cnt, frames_done = 0;
    int frame_beats, frame_le, frame_fs, last_frame_beats, last_frame_le, last_frame_fs, last_data;

    fractal_engine dut (
        .clk(clk), .reset(reset), .mode_in(mode_in),
        .width_in(width_in), .height_in(height_in),
        .cr_in(cr_in), .ci_in(ci_in), .dx_in(dx_in), .dy_in(dy_in), .x0_in(x0_in), .y0_in(y0_in),
        .data_ready(data_ready), .data(data), .data_enable(data_enable),
        .frame_start(frame_start), .line_end(line_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Escape-time count from the mathematical definition, using exact 64-bit arithmetic
    function automatic int model_count(bit mandel, int px, int py, int cr, int ci);
        longint zr, zi, ar, ai, rr, ii, ri;
        zr = mandel ? 64'sd0 : longint'(px);
        zi = mandel ? 64'sd0 : longint'(py);
        ar = mandel ? longint'(px) : longint'(cr);
        ai = mandel ? longint'(py) : longint'(ci);
        for (int it = 0; it < MAX_ITER; it++) begin
            rr = (zr * zr) >>> 28;
            ii = (zi * zi) >>> 28;
            if (rr + ii > (64'sd4 <<< 28)) return it;
            ri = (zr * zi) >>> 28;
            zr = longint'(int'(rr - ii + ar));
            zi = longint'(int'(2 * ri + ai));
        end
        return MAX_ITER;
    endfunction

    function automatic int pixel_count(int col, int row);
        bit mandel;
`ifdef FRACTAL_ENGINE_MANDELBROT_EN
        mandel = m_mode;
`else
        mandel = 1'b0;
`endif
        return model_count(mandel, m_x0 - col * m_dx, m_y0 - row * m_dy, m_cr, m_ci);
    endfunction

    // Ready generator: 0 = always ready, 1 = stalled, 2 = random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       data_ready = 1'b1;
            1:       data_ready = 1'b0;
            default: data_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare process: tracks frame/pixel position and checks every cycle away from the edge
    always @(negedge clk) begin
        if (reset) begin
            check("rst_data", data, 0);
            check("rst_enable", data_enable, 0);
            check("rst_frame_start", frame_start, 0);
            check("rst_line_end", line_end, 0);
            model_idle = 1'b1;
        end else begin
            wait_cnt++;
            if (model_idle) begin
                check("idle_no_beat", data_enable, 0);
                m_w = width_in;  m_h = height_in;  m_mode = mode_in;
                m_cr = cr_in;  m_ci = ci_in;  m_dx = dx_in;  m_dy = dy_in;  m_x0 = x0_in;  m_y0 = y0_in;
                if (m_w != 0 && m_h != 0) begin
                    model_idle = 1'b0;  m_col = 0;  m_row = 0;  wait_cnt = 0;  beat_seen = 1'b0;
                    frame_beats = 0;  frame_le = 0;  frame_fs = 0;
                    exp_cnt = pixel_count(0, 0);
                end
            end else if (data_enable) begin
                if (!beat_seen) begin
                    check("latency", wait_cnt, exp_cnt + 3);
                    beat_seen = 1'b1;
                end
                check("data", data, (exp_cnt > 255) ? 255 : exp_cnt);
                check("frame_start", frame_start, (m_col == 0 && m_row == 0));
                check("line_end", line_end, (m_col == m_w - 1));
                if (data_ready) begin
                    frame_beats++;  frame_le += line_end;  frame_fs += frame_start;  last_data = data;
                    if (m_col == m_w - 1) begin
                        m_col = 0;
                        if (m_row == m_h - 1) begin
                            model_idle = 1'b1;  frames_done++;
                            last_frame_beats = frame_beats;  last_frame_le = frame_le;  last_frame_fs = frame_fs;
                        end else begin
                            m_row++;
                        end
                    end else begin
                        m_col++;
                    end
                    if (!model_idle) begin
                        exp_cnt = pixel_count(m_col, m_row);  wait_cnt = 0;  beat_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_frames(input int n);
        int target = frames_done + n;
        int budget = 0;
        while (frames_done < target && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        if (frames_done < target) begin
            miscompares++;
            $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_done, target);
        end
    endtask

    task automatic wait_beat(input int min_col);
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(data_enable && !model_idle && m_col >= min_col) && budget < 5000);
        if (budget >= 5000) begin
            miscompares++;
            $display("FAIL beat_timeout: got no beat at col>=%0d, expected one", min_col);
        end
    endtask

    task automatic set_cfg(input int w, input int h, input bit md, input int cr, input int ci,
                           input int dx, input int dy, input int x0, input int y0);
        @(posedge clk); #1;
        width_in = 16'(w);  height_in = 16'(h);  mode_in = md;
        cr_in = cr;  ci_in = ci;  dx_in = dx;  dy_in = dy;  x0_in = x0;  y0_in = y0;
    endtask

    function automatic int rnd_fx(input int span);
        return int'($urandom_range(0, 2 * span)) - span;
    endfunction

    initial begin
        // hand-computed pins of the model itself
        check("pin_julia_zero", model_count(1'b0, 0, 0, 0, 0), 255);
        check("pin_julia_3p0", model_count(1'b0, 32'h30000000, 0, 0, 0), 0);
        check("pin_julia_1p5", model_count(1'b0, 32'h18000000, 0, 0, 0), 1);
        check("pin_julia_2p0", model_count(1'b0, 32'h20000000, 0, 0, 0), 1);
        check("pin_mandel_c2", model_count(1'b1, 32'h20000000, 0, 0, 0), 2);

        // width 4 x height 2, fast-escaping pixels, always ready
        set_cfg(4, 2, 1'b0, 0, 0, 0, 0, 32'h30000000, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_frames(1);
        check("A_beats", last_frame_beats, 8);
        check("A_line_ends", last_frame_le, 2);
        check("A_frame_starts", last_frame_fs, 1);
        check("A_data", last_data, 0);

        // all-zero Julia never escapes
        set_cfg(2, 2, 1'b0, 0, 0, 0, 0, 0, 0);
        wait_frames(2);
        check("B_data", last_data, 255);
        check("B_frame_starts", last_frame_fs, 1);

        // zero width: engine must sit idle with no beats
        set_cfg(0, 2, 1'b0, 0, 0, 0, 0, 0, 0);
        wait_frames(1);
        repeat (20) @(posedge clk);

        // randomized configurations with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 4; i++) begin
            set_cfg($urandom_range(1, 4), $urandom_range(1, 2), 1'($urandom_range(0, 1)),
                    rnd_fx(32'h10000000), rnd_fx(32'h10000000),
                    rnd_fx(32'h08000000), rnd_fx(32'h08000000),
                    rnd_fx(32'h20000000), rnd_fx(32'h20000000));
            wait_frames(2);
        end

        // backpressure: hold ready low across a valid beat
        ready_mode = 0;
        set_cfg(4, 2, 1'b0, 0, 0, 0, 0, 32'h30000000, 0);
        wait_frames(1);
        wait_beat(0);
        ready_mode = 1;
        repeat (14) @(posedge clk);
        ready_mode = 0;
        wait_frames(1);
        check("D_beats", last_frame_beats, 8);

        // width change mid-frame takes effect only at the next frame
        wait_beat(0);
        @(posedge clk); #1 width_in = 16'd8;
        wait_frames(1);
        check("E_beats_old", last_frame_beats, 8);
        wait_frames(1);
        check("E_beats_new", last_frame_beats, 16);
        check("E_line_ends", last_frame_le, 2);

        // asynchronous reset mid-line
        set_cfg(4, 2, 1'b0, 0, 0, 0, 0, 32'h30000000, 0);
        wait_frames(1);
        wait_beat(1);
        #2 reset = 1'b1;
        #1;
        check("F_async_data", data, 0);
        check("F_async_enable", data_enable, 0);
        check("F_async_frame_start", frame_start, 0);
        check("F_async_line_end", line_end, 0);
        set_cfg(1, 1, 1'b1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 reset = 1'b0;
        wait_frames(1);
        check("F_first_frame_start", last_frame_fs, 1);
        check("F_origin_data", last_data, 255);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
